// File: rtl/alu_operand_loader.sv
// Operand loader in front of the 4-bit ALU. Two push buttons are synchronized
// and debounced; a qualified "next" press steps through the A, B and opcode
// capture sequence from the switches, and a qualified "clear" press zeroes
// everything and restarts the sequence.
//
// state   | meaning
// --------+-----------------------------------------------
// LOAD_A  | waiting for next press to capture A from sw
// LOAD_B  | waiting for next press to capture B from sw
// LOAD_OP | waiting for next press to capture aluop from sw
// SHOW    | complete operand set presented, valid high
module alu_operand_loader #(
  parameter int unsigned DEB_CNT = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] aluop,
  output logic [1:0] step,
  output logic       valid
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // Counter value on which the debounced level flips; reaching DEB_CNT
  // counted cycles of disagreement means the increment to DEB_CNT is replaced
  // by the toggle.
  localparam logic [23:0] CNT_LAST = 24'(DEB_CNT - 1);

  // Bit 0 is the next button, bit 1 the clear button.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1_q;
  logic [1:0]  sync2_q;
  logic [1:0]  deb_q;
  logic [1:0]  deb_d;
  logic [1:0]  deb_prev_q;
  logic [1:0]  pulse_q;
  logic [23:0] cnt_q [2];
  logic [23:0] cnt_d [2];

  logic        next_p;
  logic        clr_p;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        valid_q, valid_d;

  assign btn_raw = {btn_clr, btn_next};

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles of disagreement, flip on qualification.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 24'd1;
        end
      end
    end
  end

  // Debounce state and rising-edge pulse, one cycle after the debounced rise.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
    end else begin
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign next_p = pulse_q[0];
  assign clr_p  = pulse_q[1];

  // Sequencer next-state and operand capture; clear takes priority over next.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (clr_p) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else if (next_p) begin
      case (state_q)
        LOAD_A: begin
          a_d     = sw;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d    = sw;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
        default: begin
          state_d = LOAD_A;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and operand registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign aluop = op_q;
  assign step  = state_q;
  assign valid = valid_q;

endmodule
